// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit common-anode seven-segment scanner with double-buffered digit store
// Optional SEG_DIM_EN adds bright[3:0] PWM dimming of the driven anode.
module seg_scan_ctrl #(
    parameter int TICK_DIV     = 12_500,
    parameter int BLANK_CYCLES = 100
) (
    input  logic       CLK100MHZ,
    input  logic       RST,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       wr_dp,
    input  logic       commit,
    input  logic [7:0] en_mask,
`ifdef SEG_DIM_EN
    input  logic [3:0] bright,
`endif
    output logic       frame_done,
    output logic [7:0] AN,
    output logic       CA,
    output logic       CB,
    output logic       CC,
    output logic       CD,
    output logic       CE,
    output logic       CF,
    output logic       CG,
    output logic       DP
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DRIVE_END = CW'(TICK_DIV - BLANK_CYCLES - 1);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t        state, state_n;
    logic [2:0]    idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          slot_end, frame_end, lit, on;
    logic [4:0]    back [8];
    logic [4:0]    front [8];
    logic [4:0]    cur;
    logic [6:0]    seg;
    logic [7:0]    mask_q;

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            state <= BLANK;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        slot_end  = (state == DRIVE) && (cnt == DRIVE_END);
        frame_end = slot_end && (idx == 3'd7);
        state_n   = state;
        idx_n     = idx;
        cnt_n     = cnt + 1'b1;
        if (state == BLANK && cnt == BLANK_END) begin
            state_n = DRIVE;
            cnt_n   = '0;
        end
        if (slot_end) begin
            state_n = BLANK;
            idx_n   = idx + 1'b1;
            cnt_n   = '0;
        end
    end

`ifdef SEG_DIM_EN
    logic [3:0] pwm_ctr, bright_q;
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            pwm_ctr  <= '0;
            bright_q <= 4'hF;
        end else begin
            pwm_ctr <= pwm_ctr + 1'b1;
            if (frame_end) bright_q <= bright;
        end
    end
    assign on = pwm_ctr <= bright_q;
`else
    assign on = 1'b1;
`endif

    // Each store entry is {nibble, dp}
    assign cur = front[idx];
    assign lit = (state == DRIVE) && mask_q[idx];

    always_comb begin
        seg = 7'b1111111;
        case (cur[4:1])
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
        endcase
    end

    // wr_ready low doubles as commit_pending
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            for (int i = 0; i < 8; i++) begin
                back[i]  <= '0;
                front[i] <= '0;
            end
            mask_q     <= 8'hFF;
            wr_ready   <= 1'b1;
            frame_done <= 1'b0;
            AN         <= 8'hFF;
            {CA, CB, CC, CD, CE, CF, CG, DP} <= 8'hFF;
        end else begin
            if (wr_valid && wr_ready) back[wr_addr] <= {wr_data, wr_dp};
            if (commit && wr_ready) wr_ready <= 1'b0;
            if (frame_end) begin
                mask_q <= en_mask;
                if (!wr_ready) begin
                    for (int i = 0; i < 8; i++) front[i] <= back[i];
                    wr_ready <= 1'b1;
                end
            end
            frame_done <= frame_end;
            AN         <= (lit && on) ? ~(8'd1 << idx) : 8'hFF;
            {CA, CB, CC, CD, CE, CF, CG, DP} <= lit ? {seg, ~cur[0]} : 8'hFF;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed checks of scan timing, double-buffer commit, masking and reset.
module tb_seg_scan_ctrl;
    logic       clk = 1'b0, rst = 1'b1;
    logic       wr_valid = 1'b0, wr_dp = 1'b0, commit = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic [7:0] en_mask = 8'hFF;
    logic       wr_ready, frame_done;
    logic [7:0] AN;
    logic       CA, CB, CC, CD, CE, CF, CG, DP;
    logic [7:0] segs;
    int         n_cmp = 0, n_bad = 0;
    int         lowcnt [8];
    logic [7:0] segv [8];
    int         fd_cnt, multi, blank_bad, rdy_hi, k;

    always #5 clk = ~clk;

    assign segs = {CA, CB, CC, CD, CE, CF, CG, DP};

    seg_scan_ctrl #(.TICK_DIV(16), .BLANK_CYCLES(2)) dut (
        .CLK100MHZ(clk), .RST(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_dp(wr_dp), .commit(commit),
        .en_mask(en_mask), .frame_done(frame_done), .AN(AN),
        .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG), .DP(DP)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] d, input logic p,
                      input logic c, input logic v);
        wr_valid = v;
        wr_addr  = a;
        wr_data  = d;
        wr_dp    = p;
        commit   = c;
        @(negedge clk);
        wr_valid = 1'b0;
        commit   = 1'b0;
    endtask

    task automatic wait_fd(output int cyc);
        cyc    = 0;
        rdy_hi = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (wr_ready && !frame_done) rdy_hi++;
        end while (!frame_done && cyc < 400);
        chk("frame_done_seen", 32'(frame_done), 32'd1);
    endtask

    task automatic run_frame();
        fd_cnt    = 0;
        multi     = 0;
        blank_bad = 0;
        for (int d = 0; d < 8; d++) begin
            lowcnt[d] = 0;
            segv[d]   = 8'h00;
        end
        repeat (128) begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
            if ($countones(~AN) > 1) multi++;
            if (AN == 8'hFF && segs != 8'hFF) blank_bad++;
            for (int d = 0; d < 8; d++)
                if (!AN[d]) begin
                    lowcnt[d]++;
                    segv[d] = segs;
                end
        end
        chk("fd_at_frame_end", 32'(frame_done), 32'd1);
        chk("fd_per_frame", 32'(fd_cnt), 32'd1);
        chk("anode_overlap", 32'(multi), 32'd0);
        chk("blank_segs", 32'(blank_bad), 32'd0);
    endtask

    task automatic check_frame(input logic [7:0] mask, input logic [63:0] exp);
        for (int d = 0; d < 8; d++) begin
            chk($sformatf("an%0d_low_cycles", d), 32'(lowcnt[d]), mask[d] ? 32'd14 : 32'd0);
            if (mask[d]) chk($sformatf("seg%0d", d), 32'(segv[d]), 32'(exp[8*d +: 8]));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(AN), 32'hFF);
        chk("rst_segs", 32'(segs), 32'hFF);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        wait_fd(k);
        chk("first_fd_latency", 32'(k), 32'd128);
        run_frame();
        check_frame(8'hFF, 64'h03030303_03030303);
        run_frame();
        check_frame(8'hFF, 64'h03030303_03030303);

        wr(3'd3, 4'hA, 1'b1, 1'b0, 1'b1);
        wr(3'd0, 4'h0, 1'b0, 1'b1, 1'b0);
        chk("rdy_after_commit", 32'(wr_ready), 32'd0);
        wait_fd(k);
        chk("rdy_low_until_swap", 32'(rdy_hi), 32'd0);
        chk("rdy_after_swap", 32'(wr_ready), 32'd1);
        run_frame();
        check_frame(8'hFF, 64'h03030303_10030303);

        wr(3'd0, 4'h7, 1'b0, 1'b1, 1'b1);
        chk("rdy_after_wr_commit", 32'(wr_ready), 32'd0);
        wr(3'd5, 4'hE, 1'b1, 1'b1, 1'b1);
        wait_fd(k);
        chk("rdy_low_pending", 32'(rdy_hi), 32'd0);
        chk("rdy_after_swap2", 32'(wr_ready), 32'd1);
        run_frame();
        check_frame(8'hFF, 64'h03030303_1003031F);

        en_mask = 8'b1111_0101;
        wait_fd(k);
        chk("period_with_mask", 32'(k), 32'd128);
        run_frame();
        check_frame(8'b1111_0101, 64'h03030303_1003031F);
        en_mask = 8'hFF;

        wr(3'd6, 4'h9, 1'b0, 1'b0, 1'b1);
        wr(3'd0, 4'h0, 1'b0, 1'b1, 1'b0);
        k = 0;
        while (AN !== 8'hDF && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("reached_digit5", 32'(AN), 32'hDF);
        chk("pending_before_rst", 32'(wr_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_an", 32'(AN), 32'hFF);
        chk("midrst_wr_ready", 32'(wr_ready), 32'd1);
        chk("midrst_segs", 32'(segs), 32'hFF);
        rst = 1'b0;
        wait_fd(k);
        chk("fd_latency_after_rst", 32'(k), 32'd128);
        run_frame();
        check_frame(8'hFF, 64'h03030303_03030303);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
